// File: rtl/joy_debounce.sv
// Joystick debounce + event FIFO: 16 raw bits -> debounced words, each level change queued once.
// Latency: raw_q 1 cycle, accept after DB_TICKS-1..DB_TICKS ticks, evt_valid 2 cycles later; full FIFO holds pend bits, no drops except coalescing.
module joy_debounce #(
    parameter int TICK_CYCLES = 2800,
    parameter int DB_TICKS    = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic       ready_in,
    input  logic [7:0] joya_raw,
    input  logic [7:0] joyb_raw,
    output logic [7:0] joya,
    output logic [7:0] joyb,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [4:0] evt_data,
    output logic       evt_overflow,
    input  logic       clr_overflow
);

    localparam int              PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int              AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [3:0]      DB_LAST   = 4'(DB_TICKS - 1);
    localparam logic [AW+1:0]   DEPTH_W   = (AW+2)'(FIFO_DEPTH);

    logic [15:0]   raw_q, stable_q, stable_d, pend_q, pend_d, accept, sel_mask;
    logic [3:0]    cnt_q [16];
    logic [3:0]    cnt_d [16];
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic [3:0]    sel_idx;
    logic          sel_any, pop, allow, push, ovf_set;
    logic          stg_vld_q, ovf_q, ovf_d;
    logic [4:0]    stg_dat_q, stg_dat_d;
    logic [4:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   occ_q, occ_d;
    logic [AW+1:0] total;

    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (!ready_in) begin
            presc_d = '0;
        end else if (presc_q == TICK_LAST) begin
            presc_d = '0;
            tick    = 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_idx = 4'(i);
                sel_any = 1'b1;
            end
        end
    end

    // A staged entry already owns a FIFO slot, so it counts toward occupancy.
    always_comb begin
        pop       = (occ_q != '0) && evt_ready;
        total     = {1'b0, occ_q} + {{(AW+1){1'b0}}, stg_vld_q};
        allow     = (total < DEPTH_W) || pop;
        push      = ready_in && sel_any && allow;
        sel_mask  = push ? (16'd1 << sel_idx) : 16'd0;
        stg_dat_d = {stable_q[sel_idx], sel_idx};
        occ_d     = occ_q + {{AW{1'b0}}, stg_vld_q} - {{AW{1'b0}}, pop};
    end

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept   = '0;
        for (int i = 0; i < 16; i++) begin
            if (raw_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == DB_LAST) begin
                    stable_d[i] = raw_q[i];
                    cnt_d[i]    = '0;
                    accept[i]   = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
        pend_d  = (pend_q & ~sel_mask) | accept;
        ovf_set = |(accept & pend_q & ~sel_mask);
        if (!ready_in) begin
            stable_d = '1;
            pend_d   = '0;
            ovf_set  = 1'b0;
            for (int i = 0; i < 16; i++) cnt_d[i] = '0;
        end
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            raw_q     <= '1;
            stable_q  <= '1;
            pend_q    <= '0;
            presc_q   <= '0;
            for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
            stg_vld_q <= 1'b0;
            stg_dat_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            raw_q     <= {joyb_raw, joya_raw};
            stable_q  <= stable_d;
            pend_q    <= pend_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            stg_vld_q <= push;
            if (push) stg_dat_q <= stg_dat_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (stg_vld_q) begin
                mem_q[wr_ptr_q] <= stg_dat_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q <= occ_d;
        end
    end

    assign joya         = stable_q[7:0];
    assign joyb         = stable_q[15:8];
    assign evt_valid    = (occ_q != '0);
    assign evt_data     = mem_q[rd_ptr_q];
    assign evt_overflow = ovf_q;

endmodule

// File: doc/joy_debounce.md
# joy_debounce

Debounce and event stage that sits directly downstream of the MCP23S17 joystick reader. It takes the two raw 8-bit joystick words and the reader's `ready` flag, and produces debounced joystick words for the LEDs and core logic. Each debounced level change is also serialised into a small event FIFO with a valid/ready handshake, so a consumer sees every press and release exactly once.

## Interface
- `TICK_CYCLES`, 2800: prescaler period in `clk` cycles (100 µs at 28 MHz).
- `DB_TICKS`, 10: ticks a bit must hold a new level before it is accepted (range 2..15).
- `FIFO_DEPTH`, 4: event FIFO entries (power of two, ≥2).

- `clk`  in  1  system clock (28 MHz).
- `RESET_N`  in  1  asynchronous active-low reset.
- `ready_in`  in  1  expander-configured flag from the reader.
- `joya_raw`  in  8  raw joystick A word (1 = released, 0 = pressed).
- `joyb_raw`  in  8  raw joystick B word, same polarity.
- `joya`  out  8  debounced A word, same polarity.
- `joyb`  out  8  debounced B word, same polarity.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_ready`  in  1  consumer accepts the head entry.
- `evt_data`  out  5  [4] = new level, [3:0] = bit index (0–7 are A, 8–15 are B).
- `evt_overflow`  out  1  sticky: an event was coalesced (lost).
- `clr_overflow`  in  1  synchronous clear of `evt_overflow`.

## Operation
- Reset (async, `RESET_N`=0) drives: `joya`/`joyb`=8'hFF, `evt_valid`=0, `evt_data`=0, `evt_overflow`=0. All counters, pending flags and FIFO pointers are cleared.
- Raw inputs are registered once (`raw_q`) before use.
- Prescaler: counts 0..`TICK_CYCLES`-1 and wraps. `tick` pulses for one cycle at the terminal count. It is held at 0 while `ready_in`=0.
- While `ready_in`=0:
  - Stable words are forced to 8'hFF.
  - Per-bit counters and pending flags are cleared.
  - No new events are generated; the FIFO keeps existing entries and can still drain.
- Per bit i (16 bits), 4-bit counter `cnt[i]`:
  - If `raw_q[i]` equals `stable[i]` on any cycle, `cnt[i]` goes to 0 (a glitch restarts the count).
  - Else, on `tick`:
    - If `cnt[i]` = `DB_TICKS`-1: `stable[i]` takes `raw_q[i]`, `cnt[i]` goes to 0, and `pend[i]` is set.
    - Otherwise `cnt[i]` increments.
- Serialiser:
  - Each cycle, the lowest-index set `pend[i]` is pushed as {`stable[i]`, i}, provided a push is allowed. The push clears that `pend[i]`.
  - At most one push per cycle.
  - A push is allowed if the FIFO is not full, or a pop happens in the same cycle.
- Coalescing: if `stable[i]` changes while `pend[i]` is already set, `pend[i]` stays set and `evt_overflow` is set. The later push carries the level current at push time.
- FIFO handshake:
  - `evt_valid` = non-empty.
  - A pop occurs when `evt_valid` and `evt_ready` are both 1.
  - `evt_data` shows the head entry and is held stable while `evt_valid`=1 and `evt_ready`=0.
  - No bypass: a push into an empty FIFO makes `evt_valid` rise the next cycle.
  - Pointers wrap modulo `FIFO_DEPTH`. A full-bit or occupancy counter distinguishes full from empty.
- `evt_overflow`: set has priority over `clr_overflow` in the same cycle.
- `joya` = `stable[7:0]`, `joyb` = `stable[15:8]`, both driven directly from flops.

## Timing
- Raw change to `raw_q` change: 1 cycle.
- Accept latency: between `DB_TICKS`-1 and `DB_TICKS` full tick periods after `raw_q` settles. The phase depends on the prescaler.
- `stable` and `joya`/`joyb` update on the clock edge where `tick`=1 and `cnt` reaches its terminal value. `pend` is set on the same edge.
- Push occurs on the next edge if allowed. `evt_valid` is visible one cycle after the push.
- Simultaneous changes on k bits: pushed on k consecutive cycles, lowest index first, subject to FIFO space.
- `ready_in` falling mid-count: counts are abandoned and outputs go to 8'hFF on the next edge. No release events are generated for this forced reset.
- `RESET_N` asserted mid-transfer: the FIFO empties immediately (async). No partial state survives.

## Test plan
(All scenarios use `TICK_CYCLES`=4, `DB_TICKS`=3, `FIFO_DEPTH`=4.)
- Reset, then `ready_in`=1, raw A/B = 8'hFF held 100 cycles -> `joya`/`joyb`=8'hFF, `evt_valid` never rises, `evt_overflow`=0.
- `joya_raw[2]` goes 1→0 and is held -> `joya`=8'hFB after 8–12 cycles. Exactly one event {0, 4'd2}, with `evt_valid` rising 2 cycles after `joya` changes.
- `joya_raw[2]` pulses low for 5 cycles, then returns high -> `joya` stays 8'hFF and no event is produced.
- `joya_raw`=8'hFE and `joyb_raw`=8'h7F on the same cycle, with `evt_ready`=1 -> events {0,0} then {0,15} on consecutive cycles; `evt_overflow`=0.
- `evt_ready`=0, 5 distinct bits change together -> FIFO holds 4 entries with `evt_data`={0,0} held. The 5th stays pending until one pop, then enters. Toggling that 5th bit again before the push sets `evt_overflow`=1, and `clr_overflow` clears it.
- `ready_in` drops while `joya`=8'hFB and the FIFO holds 2 entries -> `joya`=8'hFF next cycle, no new event, and both existing entries still drain in order.
